instr_encoder: RTL

//  Inverse of the instruction decoder: packs ARM-subset fields (Cond/Op/Funct/Rd/Rn/Imm) into 32-bit words.

---
 rtl/instr_encoder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs ARM-subset fields into 32-bit words, buffers them in a FIFO and streams them to imem.
// Optional build macro ENC_CHECK_EN: illegal Op encodings are replaced by a NOP and flag Err.
module instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Start,
    input  logic [AW-1:0] BaseAddr,
    input  logic          InValid,
    output logic          InReady,
    input  logic          InLast,
    input  logic [3:0]    Cond,
    input  logic [1:0]    Op,
    input  logic [5:0]    Funct,
    input  logic [3:0]    Rn,
    input  logic [3:0]    Rd,
    input  logic [23:0]   Imm,
    input  logic          IMemBusy,
    output logic          IMemWE,
    output logic [AW-1:0] IMemAddr,
    output logic [31:0]   IMemWD,
    output logic          Done,
    output logic          Err,
    output logic [AW-1:0] WordCount
);

    localparam int unsigned PW = $clog2(DEPTH);
`ifdef ENC_CHECK_EN
    localparam logic [31:0] NopWord = 32'hE1A00000;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [31:0]   fifo_mem_q [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          fifo_empty, fifo_full;

    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [AW-1:0] next_addr_q, next_addr_d;
    logic [31:0]   imem_wd_q, imem_wd_d;
    logic [AW-1:0] word_count_q, word_count_d;

    logic [31:0]   enc_word;
    logic          push, pop;
    logic [AW-1:0] base_aligned;

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                          (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign base_aligned = {BaseAddr[AW-1:2], 2'b00};

    assign InReady = (state_q == StRun) && !fifo_full;
    assign push    = InValid && InReady;
    assign pop     = ((state_q == StRun) || (state_q == StFlush)) && !fifo_empty && !IMemBusy;

    // Branch format reuses the Funct/Rn/Rd/Imm[11:0] span for the 24-bit offset.
`ifdef ENC_CHECK_EN
    logic enc_illegal;

    always_comb begin
        enc_illegal = (Op == 2'b11) || ((Op == 2'b10) && !Funct[5]);
        if (enc_illegal) begin
            enc_word = NopWord;
        end else if (Op == 2'b10) begin
            enc_word = {Cond, Op, Funct[5:4], Imm};
        end else begin
            enc_word = {Cond, Op, Funct, Rn, Rd, Imm[11:0]};
        end
    end
`else
    always_comb begin
        if (Op == 2'b10) begin
            enc_word = {Cond, Op, Funct[5:4], Imm};
        end else begin
            enc_word = {Cond, Op, Funct, Rn, Rd, Imm[11:0]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PW-1:0]] <= enc_word;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        imem_we_d    = pop;
        imem_addr_d  = imem_addr_q;
        next_addr_d  = next_addr_q;
        imem_wd_d    = imem_wd_q;
        word_count_d = word_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // IMemAddr carries the address of the write issued next cycle; next_addr_q runs ahead.
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            imem_wd_d    = fifo_mem_q[rd_ptr_q[PW-1:0]];
            imem_addr_d  = next_addr_q;
            next_addr_d  = next_addr_q + AW'(4);
            word_count_d = word_count_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d      = StRun;
                    imem_addr_d  = base_aligned;
                    next_addr_d  = base_aligned;
                    word_count_d = '0;
                end
            end
            StRun: begin
                if (push && InLast) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (fifo_empty && !imem_we_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            next_addr_q  <= '0;
            imem_wd_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            next_addr_q  <= next_addr_d;
            imem_wd_q    <= imem_wd_d;
            word_count_q <= word_count_d;
        end
    end

`ifdef ENC_CHECK_EN
    logic err_q, err_d;

    // Sticky until the next program starts.
    always_comb begin
        err_d = err_q;
        if ((state_q == StIdle) && Start) begin
            err_d = 1'b0;
        end else if (push && enc_illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign IMemWE    = imem_we_q;
    assign IMemAddr  = imem_addr_q;
    assign IMemWD    = imem_wd_q;
    assign Done      = (state_q == StDone);
    assign WordCount = word_count_q;

endmodule
